// File: rtl/vita49_pack_sched_if.sv
// rtl/vita49_pack_sched_if.sv - monitor taps of the packer master AXI-Stream handshake
interface vita49_pack_sched_if;
  logic pkt_tvalid;
  logic pkt_tready;
  logic pkt_tlast;

  modport master (output pkt_tvalid, output pkt_tready, output pkt_tlast);
  modport slave  (input  pkt_tvalid, input  pkt_tready, input  pkt_tlast);
endinterface

// File: rtl/vita49_pack_sched.sv
// rtl/vita49_pack_sched.sv - timed-start burst scheduler for the VITA-49 packer
module vita49_pack_sched #(
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                     AXIS_ACLK,
  input  logic                     AXIS_ARESET,
  input  logic [31:0]              sched_ctrl,
  input  logic [31:0]              start_sec,
  input  logic [63:0]              start_fsec,
  input  logic [15:0]              num_pkts,
  input  logic [31:0]              timestamp_sec,
  input  logic [63:0]              timestamp_fsec,
  vita49_pack_sched_if.slave       pkt,
  output logic [31:0]              pack_ctrl,
  output logic                     src_en,
  output logic [31:0]              sched_status,
  output logic                     done_pulse
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state;

  logic        arm_r, abort_r, pass_r, trl_r, arm_prev, arm_edge_r;
  logic [31:0] start_sec_r, ts_sec_r, start_sec_c;
  logic [63:0] start_fsec_r, ts_fsec_r, start_fsec_c;
  logic [15:0] num_pkts_r, num_c, pkt_cnt;
  logic        pass_c, trl_c;
  logic        ts_hit, armed_wait, first_cmp;
  logic [FCW-1:0] flush_cnt;
  logic        done_b, aborted_b, late_b;
  logic        start_o, reset_o;

  logic        beat;
  logic [15:0] cnt_inc;
  logic        unused_ctrl;

  assign beat        = pkt.pkt_tvalid & pkt.pkt_tready & pkt.pkt_tlast;
  assign cnt_inc     = pkt_cnt + 16'd1;
  assign unused_ctrl = ^sched_ctrl[31:4];

  assign pack_ctrl    = {28'd0, trl_c, pass_c, reset_o, start_o};
  assign sched_status = {pkt_cnt, 8'd0, 2'b00, late_b, aborted_b, done_b, state};

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      state        <= S_IDLE;
      arm_r        <= 1'b0;
      abort_r      <= 1'b0;
      pass_r       <= 1'b0;
      trl_r        <= 1'b0;
      arm_prev     <= 1'b0;
      arm_edge_r   <= 1'b0;
      start_sec_r  <= '0;
      start_fsec_r <= '0;
      num_pkts_r   <= '0;
      ts_sec_r     <= '0;
      ts_fsec_r    <= '0;
      start_sec_c  <= '0;
      start_fsec_c <= '0;
      num_c        <= '0;
      pass_c       <= 1'b0;
      trl_c        <= 1'b0;
      ts_hit       <= 1'b0;
      armed_wait   <= 1'b0;
      first_cmp    <= 1'b0;
      flush_cnt    <= '0;
      pkt_cnt      <= '0;
      done_b       <= 1'b0;
      aborted_b    <= 1'b0;
      late_b       <= 1'b0;
      start_o      <= 1'b0;
      reset_o      <= 1'b0;
      src_en       <= 1'b0;
      done_pulse   <= 1'b0;
    end else begin
      arm_r        <= sched_ctrl[0];
      abort_r      <= sched_ctrl[1];
      pass_r       <= sched_ctrl[2];
      trl_r        <= sched_ctrl[3];
      start_sec_r  <= start_sec;
      start_fsec_r <= start_fsec;
      num_pkts_r   <= num_pkts;
      ts_sec_r     <= timestamp_sec;
      ts_fsec_r    <= timestamp_fsec;
      arm_prev     <= arm_r;
      arm_edge_r   <= arm_r & ~arm_prev;
      ts_hit       <= ({ts_sec_r, ts_fsec_r} >= {start_sec_c, start_fsec_c});
      done_pulse   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (arm_edge_r) begin
            start_sec_c  <= start_sec_r;
            start_fsec_c <= start_fsec_r;
            num_c        <= num_pkts_r;
            pass_c       <= pass_r;
            trl_c        <= trl_r;
            done_b       <= 1'b0;
            aborted_b    <= 1'b0;
            late_b       <= 1'b0;
            pkt_cnt      <= '0;
            armed_wait   <= 1'b1;
            first_cmp    <= 1'b1;
            state        <= S_ARMED;
          end
        end

        S_ARMED: begin
          // ts_hit lags the capture by one cycle, so the first cycle here is stale.
          if (abort_r) begin
            aborted_b <= 1'b1;
            reset_o   <= 1'b1;
            flush_cnt <= '0;
            state     <= S_FLUSH;
          end else if (armed_wait) begin
            armed_wait <= 1'b0;
          end else if (ts_hit) begin
            late_b  <= first_cmp;
            start_o <= 1'b1;
            src_en  <= 1'b1;
            state   <= S_RUN;
          end else begin
            first_cmp <= 1'b0;
          end
        end

        S_RUN: begin
          if (beat) begin
            pkt_cnt <= cnt_inc;
          end
          // Completion takes priority over a coincident abort.
          if ((beat && (num_c != 16'd0) && (cnt_inc == num_c)) || abort_r) begin
            if (!(beat && (num_c != 16'd0) && (cnt_inc == num_c))) begin
              aborted_b <= 1'b1;
            end
            start_o   <= 1'b0;
            src_en    <= 1'b0;
            reset_o   <= 1'b1;
            flush_cnt <= '0;
            state     <= S_FLUSH;
          end
        end

        S_FLUSH: begin
          if (flush_cnt == FCW'(FLUSH_CYCLES - 1)) begin
            reset_o    <= 1'b0;
            done_b     <= 1'b1;
            done_pulse <= 1'b1;
            state      <= S_DONE;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vita49_pack_sched.sv
// tb/tb_vita49_pack_sched.sv - self-checking bench for vita49_pack_sched
module tb_vita49_pack_sched;
  localparam int      FC   = 4;
  localparam longint  STEP = 1000;

  logic        AXIS_ACLK = 1'b0;
  logic        AXIS_ARESET = 1'b1;
  logic [31:0] sched_ctrl = '0;
  logic [31:0] start_sec = '0;
  logic [63:0] start_fsec = '0;
  logic [15:0] num_pkts = '0;
  logic [31:0] timestamp_sec = '0;
  logic [63:0] timestamp_fsec;
  logic [31:0] pack_ctrl;
  logic        src_en;
  logic [31:0] sched_status;
  logic        done_pulse;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int rst_hi = 0;
  int done_cnt = 0;

  vita49_pack_sched_if pkt_if ();

  vita49_pack_sched #(.FLUSH_CYCLES(FC)) dut (
    .AXIS_ACLK      (AXIS_ACLK),
    .AXIS_ARESET    (AXIS_ARESET),
    .sched_ctrl     (sched_ctrl),
    .start_sec      (start_sec),
    .start_fsec     (start_fsec),
    .num_pkts       (num_pkts),
    .timestamp_sec  (timestamp_sec),
    .timestamp_fsec (timestamp_fsec),
    .pkt            (pkt_if.slave),
    .pack_ctrl      (pack_ctrl),
    .src_en         (src_en),
    .sched_status   (sched_status),
    .done_pulse     (done_pulse)
  );

  always #5 AXIS_ACLK = ~AXIS_ACLK;
  always @(posedge AXIS_ACLK) cyc <= cyc + 1;
  assign timestamp_fsec = 64'(cyc) * 64'(STEP);

  always @(negedge AXIS_ACLK) begin
    if (pack_ctrl[1]) rst_hi++;
    if (done_pulse) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge AXIS_ACLK);
      #1;
    end
  endtask

  task automatic beat(input logic v, input logic r, input logic l);
    pkt_if.pkt_tvalid = v;
    pkt_if.pkt_tready = r;
    pkt_if.pkt_tlast  = l;
    tick();
    pkt_if.pkt_tvalid = 1'b0;
    pkt_if.pkt_tready = 1'b0;
    pkt_if.pkt_tlast  = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int i = 0;
    while (sched_status[2:0] !== st && i < budget) begin
      tick();
      i++;
    end
    check(tag, sched_status[2:0], st);
  endtask

  task automatic arm(input logic pass, input logic trl);
    sched_ctrl = {28'd0, trl, pass, 1'b0, 1'b1};
  endtask

  // Sends n counted handshakes with random gaps and random non-counting beats.
  task automatic send_counted(input int n, output int exp_cnt);
    exp_cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick($urandom_range(0, 2));
      case ($urandom_range(0, 2))
        0: beat(1'b1, 1'b0, 1'b1);
        1: beat(1'b1, 1'b1, 1'b0);
        default: ;
      endcase
      beat(1'b1, 1'b1, 1'b1);
      exp_cnt++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c_lim, a_cyc, f, exp, rb, db, nb;
    logic pass;

    pkt_if.pkt_tvalid = 1'b0;
    pkt_if.pkt_tready = 1'b0;
    pkt_if.pkt_tlast  = 1'b0;

    tick(3);
    check("rst_pack_ctrl", pack_ctrl, 32'h0);
    check("rst_src_en", src_en, 1'b0);
    check("rst_status", sched_status, 32'h0);
    check("rst_done_pulse", done_pulse, 1'b0);
    AXIS_ARESET = 1'b0;
    tick(2);

    // Future start, three packets, trailer enabled
    c_lim = cyc + 100;
    start_sec  = '0;
    start_fsec = 64'(c_lim) * 64'(STEP);
    num_pkts   = 16'd3;
    arm(1'b0, 1'b1);
    tick(2);
    check("arm_lat_early", sched_status[2:0], 3'd0);
    tick();
    check("arm_lat", sched_status[2:0], 3'd1);
    sched_ctrl = '0;
    repeat ($urandom_range(1, 3)) begin
      tick($urandom_range(0, 3));
      beat(1'b1, 1'b1, 1'b1);
    end
    wait_state(3'd2, 200, "a_run_wait");
    check("a_start_lat", 64'(cyc), 64'(c_lim + 3));
    check("a_pack_ctrl_run", pack_ctrl, 32'h9);
    check("a_src_en_run", src_en, 1'b1);
    rb = rst_hi;
    db = done_cnt;
    send_counted(3, exp);
    f = cyc;
    check("a_flush_entry", {src_en, pack_ctrl[1:0]}, 3'b010);
    beat(1'b1, 1'b1, 1'b1);
    tick(4);
    check("a_idle_cycle", 64'(cyc), 64'(f + 5));
    check("a_status", sched_status, {16'(exp), 16'h0008});
    check("a_flush_len", 64'(rst_hi - rb), 64'(FC));
    check("a_done_pulses", 64'(done_cnt - db), 64'd1);
    check("a_pack_ctrl_idle", pack_ctrl, 32'h8);

    // Start already in the past: seconds ahead, fraction behind
    timestamp_sec = 32'd5;
    start_sec     = 32'd4;
    start_fsec    = '1;
    nb   = $urandom_range(1, 4);
    pass = 1'($urandom_range(0, 1));
    num_pkts = 16'(nb);
    arm(pass, 1'b0);
    tick(3);
    check("b_armed", sched_status[2:0], 3'd1);
    a_cyc = cyc;
    sched_ctrl = '0;
    wait_state(3'd2, 10, "b_run_wait");
    check("b_late_lat", 64'(cyc), 64'(a_cyc + 2));
    check("b_late_bit", sched_status[5], 1'b1);
    sched_ctrl = {28'd0, 1'b1, ~pass, 1'b0, 1'b1};
    tick(4);
    check("b_rearm_ignored", sched_status[2:0], 3'd2);
    check("b_cfg_kept", pack_ctrl[3:2], {1'b0, pass});
    sched_ctrl = '0;
    send_counted(nb, exp);
    tick(5);
    check("b_status", sched_status, {16'(exp), 16'h0028});
    check("b_pack_ctrl_idle", pack_ctrl, {28'd0, 1'b0, pass, 2'b00});
    timestamp_sec = '0;
    start_sec     = '0;

    // Unlimited burst wrapping the packet counter, ended by abort
    start_fsec = 64'(cyc + 10) * 64'(STEP);
    num_pkts   = 16'd0;
    arm(1'b0, 1'b0);
    tick(3);
    sched_ctrl = '0;
    wait_state(3'd2, 50, "c_run_wait");
    rb = rst_hi;
    db = done_cnt;
    pkt_if.pkt_tvalid = 1'b1;
    pkt_if.pkt_tready = 1'b1;
    pkt_if.pkt_tlast  = 1'b1;
    tick(70000);
    pkt_if.pkt_tvalid = 1'b0;
    pkt_if.pkt_tready = 1'b0;
    pkt_if.pkt_tlast  = 1'b0;
    sched_ctrl = 32'h2;
    tick();
    check("c_abort_lat1", sched_status[2:0], 3'd2);
    tick();
    check("c_abort_lat2", sched_status[2:0], 3'd3);
    tick(5);
    check("c_status", sched_status, {16'(70000 % 65536), 16'h0018});
    check("c_flush_len", 64'(rst_hi - rb), 64'(FC));
    check("c_done_pulses", 64'(done_cnt - db), 64'd1);
    sched_ctrl = '0;
    tick(2);

    // Abort coinciding with the final packet
    start_fsec = 64'(cyc + 10) * 64'(STEP);
    num_pkts   = 16'd3;
    arm(1'b0, 1'b0);
    tick(3);
    sched_ctrl = '0;
    wait_state(3'd2, 50, "d_run_wait");
    send_counted(2, exp);
    sched_ctrl = 32'h2;
    tick();
    beat(1'b1, 1'b1, 1'b1);
    exp++;
    sched_ctrl = '0;
    tick(5);
    check("d_status", sched_status, {16'(exp), 16'h0008});

    // Reset in the middle of a burst, then a normal burst
    start_fsec = 64'(cyc + 10) * 64'(STEP);
    num_pkts   = 16'd5;
    arm(1'b1, 1'b1);
    tick(3);
    sched_ctrl = '0;
    wait_state(3'd2, 50, "e_run_wait");
    beat(1'b1, 1'b1, 1'b1);
    AXIS_ARESET = 1'b1;
    tick();
    check("e_rst_pack_ctrl", pack_ctrl, 32'h0);
    check("e_rst_src_en", src_en, 1'b0);
    check("e_rst_status", sched_status, 32'h0);
    AXIS_ARESET = 1'b0;
    tick(2);
    start_fsec = 64'(cyc + 20) * 64'(STEP);
    num_pkts   = 16'd1;
    arm(1'b0, 1'b1);
    tick(3);
    sched_ctrl = '0;
    wait_state(3'd2, 60, "e_run_wait2");
    send_counted(1, exp);
    tick(5);
    check("e_status", sched_status, {16'(exp), 16'h0008});
    check("e_pack_ctrl_idle", pack_ctrl, 32'h8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
